// File: rtl/logic_op_pkg.sv
// Shared opcode and FSM state types for the logic-op arbiter block.
package logic_op_pkg;

    typedef enum logic [1:0] {
        OP_NOT = 2'b00,
        OP_AND = 2'b01,
        OP_OR  = 2'b10,
        OP_XOR = 2'b11
    } op_e;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_e;

endpackage

// File: rtl/logic_op_unit.sv
// Combinational bitwise logic unit: NOT A, A AND B, A OR B, A XOR B.
module logic_op_unit
    import logic_op_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  op_e              op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] y
);

    always_comb begin
        y = '0;
        case (op)
            OP_NOT:  y = ~a;
            OP_AND:  y = a & b;
            OP_OR:   y = a | b;
            OP_XOR:  y = a ^ b;
            default: y = '0;
        endcase
    end

endmodule

// File: rtl/logic_op_arbiter.sv
// Round-robin arbiter feeding a shared logic-op unit into a single-entry
// result register with valid/ready handshake on both sides.
module logic_op_arbiter
    import logic_op_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [N_REQ-1:0]         req_valid,
    output logic [N_REQ-1:0]         req_ready,
    input  logic [2*N_REQ-1:0]       req_op,
    input  logic [WIDTH*N_REQ-1:0]   req_a,
    input  logic [WIDTH*N_REQ-1:0]   req_b,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [$clog2(N_REQ)-1:0] rsp_id,
    output logic [WIDTH-1:0]         rsp_data
);

    localparam int IDW = $clog2(N_REQ);

    state_e           state, state_nxt;
    logic [IDW-1:0]   ptr;
    logic [IDW-1:0]   gnt_idx;
    logic [IDW-1:0]   cand;
    logic             gnt_found;
    logic             free;
    logic             transfer;
    int unsigned      pos;

    op_e              op_arr [N_REQ];
    logic [WIDTH-1:0] a_arr  [N_REQ];
    logic [WIDTH-1:0] b_arr  [N_REQ];
    op_e              sel_op;
    logic [WIDTH-1:0] sel_a, sel_b, result;

    for (genvar i = 0; i < N_REQ; i++) begin : g_unpack
        assign op_arr[i] = op_e'(req_op[2*i+1:2*i]);
        assign a_arr[i]  = req_a[WIDTH*i+WIDTH-1:WIDTH*i];
        assign b_arr[i]  = req_b[WIDTH*i+WIDTH-1:WIDTH*i];
    end

    // First valid index scanning ptr, ptr+1, ... modulo N_REQ.
    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = '0;
        cand      = '0;
        pos       = 0;
        for (int unsigned k = 0; k < N_REQ; k++) begin
            pos  = (int'(ptr) + k) % N_REQ;
            cand = IDW'(pos);
            if (!gnt_found && req_valid[cand]) begin
                gnt_found = 1'b1;
                gnt_idx   = cand;
            end
        end
    end

    assign free      = (state == EMPTY) || rsp_ready;
    assign rsp_valid = (state == FULL);

    always_comb begin
        req_ready = '0;
        if (!reset && free && gnt_found) begin
            req_ready[gnt_idx] = 1'b1;
        end
    end

    assign transfer = |(req_valid & req_ready);

    assign sel_op = op_arr[gnt_idx];
    assign sel_a  = a_arr[gnt_idx];
    assign sel_b  = b_arr[gnt_idx];

    logic_op_unit #(
        .WIDTH(WIDTH)
    ) u_unit (
        .op(sel_op),
        .a (sel_a),
        .b (sel_b),
        .y (result)
    );

    always_comb begin
        state_nxt = state;
        case (state)
            EMPTY:   if (transfer) state_nxt = FULL;
            FULL:    if (rsp_ready && !transfer) state_nxt = EMPTY;
            default: state_nxt = EMPTY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= EMPTY;
            ptr      <= '0;
            rsp_data <= '0;
            rsp_id   <= '0;
        end else begin
            state <= state_nxt;
            if (transfer) begin
                rsp_data <= result;
                rsp_id   <= gnt_idx;
                ptr      <= (gnt_idx == IDW'(N_REQ - 1)) ? '0 : gnt_idx + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_logic_op_arbiter.sv
// Directed, table-driven self-checking bench for logic_op_arbiter (N_REQ=4, WIDTH=8).
module tb_logic_op_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  req_valid;
    logic [3:0]  req_ready;
    logic [7:0]  req_op;
    logic [31:0] req_a, req_b;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [1:0]  rsp_id;
    logic [7:0]  rsp_data;

    logic [1:0]  op_arr [4];
    logic [7:0]  a_arr  [4];
    logic [7:0]  b_arr  [4];

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 4; g++) begin : g_pack
        assign req_op[2*g+1:2*g] = op_arr[g];
        assign req_a[8*g+7:8*g]  = a_arr[g];
        assign req_b[8*g+7:8*g]  = b_arr[g];
    end

    logic_op_arbiter #(
        .N_REQ(4),
        .WIDTH(8)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_op   (req_op),
        .req_a    (req_a),
        .req_b    (req_b),
        .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready),
        .rsp_id   (rsp_id),
        .rsp_data (rsp_data)
    );

    typedef struct {
        int         id;
        logic [1:0] op;
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] exp;
    } vec_t;

    vec_t vt [8];
    logic [7:0] cont_exp [4];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Called just after a negedge with inputs set: checks req_ready, clocks,
    // then checks the registered response, and returns at the next negedge.
    task automatic cycle(input string nm, input logic [3:0] exp_rdy, input logic exp_v,
                         input logic [1:0] exp_id, input logic [7:0] exp_d);
        #1;
        chk({nm, ".req_ready"}, 32'(req_ready), 32'(exp_rdy));
        @(posedge clk);
        #1;
        chk({nm, ".rsp_valid"}, 32'(rsp_valid), 32'(exp_v));
        if (exp_v) begin
            chk({nm, ".rsp_id"}, 32'(rsp_id), 32'(exp_id));
            chk({nm, ".rsp_data"}, 32'(rsp_data), 32'(exp_d));
        end
        @(negedge clk);
    endtask

    task automatic set_req(input int i, input logic [1:0] op, input logic [7:0] a, input logic [7:0] b);
        op_arr[i] = op;
        a_arr[i]  = a;
        b_arr[i]  = b;
    endtask

    initial begin
        vt[0] = '{0, 2'b00, 8'hCA, 8'h0F, 8'h35};
        vt[1] = '{1, 2'b01, 8'hCA, 8'h0F, 8'h0A};
        vt[2] = '{2, 2'b10, 8'hCA, 8'h0F, 8'hCF};
        vt[3] = '{3, 2'b11, 8'hCA, 8'h0F, 8'hC5};
        vt[4] = '{1, 2'b11, 8'hFF, 8'hFF, 8'h00};
        vt[5] = '{2, 2'b01, 8'h55, 8'hAA, 8'h00};
        vt[6] = '{0, 2'b10, 8'h55, 8'hAA, 8'hFF};
        vt[7] = '{3, 2'b00, 8'h00, 8'h5A, 8'hFF};
        cont_exp[0] = 8'h35;
        cont_exp[1] = 8'h0A;
        cont_exp[2] = 8'hCF;
        cont_exp[3] = 8'hC5;

        for (int i = 0; i < 4; i++) set_req(i, 2'b00, 8'h00, 8'h00);
        reset     = 1'b1;
        req_valid = 4'b1111;
        rsp_ready = 1'b0;

        // Reset: all requesters valid, nothing may be accepted.
        @(negedge clk);
        #1;
        chk("reset.req_ready", 32'(req_ready), 32'h0);
        @(posedge clk);
        #1;
        chk("reset.rsp_valid", 32'(rsp_valid), 32'h0);
        chk("reset.rsp_data", 32'(rsp_data), 32'h0);
        chk("reset.rsp_id", 32'(rsp_id), 32'h0);
        @(negedge clk);

        // Single request right after reset: req 2, AND F0 & 3C.
        reset     = 1'b0;
        req_valid = 4'b0100;
        set_req(2, 2'b01, 8'hF0, 8'h3C);
        cycle("single", 4'b0100, 1'b1, 2'd2, 8'h30);

        // Opcode/requester table, back-to-back with rsp_ready high.
        rsp_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            set_req(vt[i].id, vt[i].op, vt[i].a, vt[i].b);
            req_valid = 4'(1 << vt[i].id);
            cycle($sformatf("vec%0d", i), 4'(1 << vt[i].id), 1'b1, 2'(vt[i].id), vt[i].exp);
        end

        req_valid = 4'b0000;
        cycle("drain", 4'b0000, 1'b0, 2'd0, 8'h00);

        // Contention: ptr is 0 after the last table grant to requester 3.
        for (int i = 0; i < 4; i++) set_req(i, 2'(i), 8'hCA, 8'h0F);
        req_valid = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            cycle($sformatf("contend%0d", k), 4'(1 << (k % 4)), 1'b1, 2'(k % 4), cont_exp[k % 4]);
        end

        // Backpressure: hold 0xA5 from requester 1.
        req_valid = 4'b0010;
        set_req(1, 2'b11, 8'hF0, 8'h55);
        cycle("bp.load", 4'b0010, 1'b1, 2'd1, 8'hA5);
        rsp_ready = 1'b0;
        req_valid = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            cycle($sformatf("bp.hold%0d", k), 4'b0000, 1'b1, 2'd1, 8'hA5);
        end
        rsp_ready = 1'b1;
        cycle("bp.release", 4'b0100, 1'b1, 2'd2, 8'hCF);

        // Reset while FULL and stalled.
        rsp_ready = 1'b0;
        reset     = 1'b1;
        cycle("midrst", 4'b0000, 1'b0, 2'd0, 8'h00);
        chk("midrst.rsp_data", 32'(rsp_data), 32'h0);
        chk("midrst.rsp_id", 32'(rsp_id), 32'h0);
        reset = 1'b0;
        cycle("midrst.first", 4'b0001, 1'b1, 2'd0, 8'h35);

        // Pointer wrap: 3 alone, then 0 and 3.
        rsp_ready = 1'b1;
        req_valid = 4'b1000;
        cycle("wrap.g3", 4'b1000, 1'b1, 2'd3, 8'hC5);
        req_valid = 4'b1001;
        cycle("wrap.g0", 4'b0001, 1'b1, 2'd0, 8'h35);
        req_valid = 4'b0000;
        cycle("wrap.drain", 4'b0000, 1'b0, 2'd0, 8'h00);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/logic_op_arbiter.md
LOGIC_OP_ARBITER -- requirements
Module: logic_op_arbiter

Interface
REQ-001 SHALL have parameter N_REQ, default 4, meaning number of requesters (2..8).
REQ-002 SHALL have parameter WIDTH, default 8, meaning operand and result bit width.
REQ-003 SHALL have port clk  input  1  meaning the single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset  input  1  meaning synchronous, active-high reset.
REQ-005 SHALL have port req_valid  input  N_REQ  meaning per-requester request valid.
REQ-006 SHALL have port req_ready  output  N_REQ  meaning per-requester accept, at most one bit high.
REQ-007 SHALL have port req_op  input  2*N_REQ  meaning per-requester opcode, requester i in bits [2i+1:2i].
REQ-008 SHALL have port req_a  input  WIDTH*N_REQ  meaning per-requester operand A, packed like req_op.
REQ-009 SHALL have port req_b  input  WIDTH*N_REQ  meaning per-requester operand B, packed like req_op.
REQ-010 SHALL have port rsp_valid  output  1  meaning the result register holds a result.
REQ-011 SHALL have port rsp_ready  input  1  meaning the consumer takes the result this cycle.
REQ-012 SHALL have port rsp_id  output  clog2(N_REQ)  meaning the index of the requester that owns rsp_data.
REQ-013 SHALL have port rsp_data  output  WIDTH  meaning the registered result.

Function
REQ-014 SHALL decode opcodes as: 00 = NOT A (B ignored), 01 = A AND B, 10 = A OR B, 11 = A XOR B, all bitwise across WIDTH bits.
REQ-015 SHALL implement a two-state FSM, EMPTY and FULL, where rsp_valid = (state == FULL).
REQ-016 SHALL treat the result register as free when state is EMPTY, or when state is FULL and rsp_ready is 1.
REQ-017 SHALL, while the result register is free and any req_valid is high, set exactly one req_ready bit, chosen by the round-robin rule; otherwise all req_ready bits SHALL be 0.
REQ-018 SHALL define a transfer as req_valid[i] & req_ready[i] in the same cycle; req_ready may depend combinationally on req_valid.
REQ-019 SHALL give round-robin priority starting at pointer ptr, granting the first valid index in ptr, ptr+1, ..., wrapping modulo N_REQ.
REQ-020 SHALL, on a grant to index g, update ptr to (g+1) mod N_REQ on the next edge, and SHALL leave ptr unchanged when there is no grant.
REQ-021 SHALL, on a transfer, register the op result into rsp_data and g into rsp_id, with rsp_valid high on the next cycle (latency 1).
REQ-022 SHALL hold rsp_data and rsp_id stable while state is FULL and rsp_ready is 0.
REQ-023 SHALL make the following FSM transitions:
  - EMPTY to FULL on a transfer.
  - FULL to FULL on rsp_ready together with a transfer (back-to-back, one result per cycle).
  - FULL to EMPTY on rsp_ready with no transfer.
  - Otherwise, hold the current state.
REQ-024 SHALL ignore rsp_ready while state is EMPTY.
REQ-025 SHALL not starve any requester: a requester that holds req_valid high SHALL be granted within N_REQ grants.

Reset
REQ-026 SHALL, on reset high at a clock edge, set state to EMPTY, rsp_valid to 0, rsp_data to 0, rsp_id to 0 and ptr to 0.
REQ-027 SHALL drive all req_ready bits to 0 in any cycle where reset is high.
REQ-028 SHALL discard any held result when reset is asserted mid-operation; the discarded result is never presented.
REQ-029 SHALL accept new requests in the first cycle after reset deasserts.

Structure
REQ-030 SHALL take the opcode enum (OP_NOT, OP_AND, OP_OR, OP_XOR) and the FSM state enum from shared package logic_op_pkg.
REQ-031 SHALL instantiate one combinational sub-module, logic_op_unit (op, a, b -> y, WIDTH-parameterised), as the shared datapath.

Verification
REQ-032 SHALL cover single request: after reset, req 2 sends op=01, a=0xF0, b=0x3C -> next cycle rsp_valid=1, rsp_id=2, rsp_data=0x30.
REQ-033 SHALL cover contention: all 4 requesters valid with rsp_ready held at 1 -> grants in order 0,1,2,3,0, one per cycle, with correct ids on rsp_id.
REQ-034 SHALL cover backpressure: rsp_ready=0 with a result of 0xA5 held -> rsp_data stays 0xA5 and req_ready stays 0 for 5 cycles; when rsp_ready rises, the next request is accepted in that same cycle.
REQ-035 SHALL cover every opcode: a=0xCA, b=0x0F -> NOT gives 0x35, AND gives 0x0A, OR gives 0xCF, XOR gives 0xC5.
REQ-036 SHALL cover reset mid-operation: state FULL with rsp_ready=0, assert reset for 1 cycle -> rsp_valid=0, ptr=0, and the next grant goes to requester 0 when all requesters are valid.
REQ-037 SHALL cover pointer wrap: only requester 3 valid, then requesters 0 and 3 valid -> grant 3, then grant 0.
